// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Round-robin owner of a single shared system bus. Grants one master at a
//   time, holds the grant while that master keeps its request high, and then
//   inserts TURN_CYCLES dead cycles before the next owner so two drivers never
//   fight on the bus. While nobody owns the bus and no turnaround is running,
//   the bus is parked (driven low) so slave chip-select decode sees clean levels.
//
//   Optional feature (macro BUS_ARBITER_TIMEOUT_EN):
//     A grant held for TIMEOUT_CYCLES cycles is revoked, the owner receives a
//     one-cycle bus_err pulse, and it is excluded from arbitration until it has
//     dropped its request for at least one cycle. Without the macro bus_err is
//     tied low and a grant may be held indefinitely.
//
// Parameters
//   NUM_MASTERS    number of requesting masters (2..16)
//   TURN_CYCLES    dead cycles after a grant ends (>=1)
//   TIMEOUT_CYCLES maximum grant length with the optional feature (>=2)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active high
//   req        per-master request, held for the whole transaction
//   gnt        one-hot grant (or zero)
//   gnt_valid  OR of gnt
//   gnt_id     index of the granted master, 0 when no grant
//   bus_park   bus-side mux drives address/data/control to 0
//   bus_err    one-cycle timeout pulse to the offending master
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int TURN_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         req,
    output logic [NUM_MASTERS-1:0]         gnt,
    output logic                           gnt_valid,
    output logic [$clog2(NUM_MASTERS)-1:0] gnt_id,
    output logic                           bus_park,
    output logic [NUM_MASTERS-1:0]         bus_err
);

    localparam int IDW = $clog2(NUM_MASTERS);
    localparam int TCW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 16 || TURN_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("bus_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]         owner_q, owner_d;
    logic [IDW-1:0]         ptr_q, ptr_d;
    logic [TCW-1:0]         turn_cnt_q, turn_cnt_d;

    logic [NUM_MASTERS-1:0] arb_req;    // requests eligible for arbitration
    logic                   timeout;    // current grant must be revoked now
    logic                   win_found;
    logic [IDW-1:0]         win_idx;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYCLES);

    logic [TOW-1:0]         to_cnt_q, to_cnt_d;
    logic [NUM_MASTERS-1:0] mask_q, mask_d;
    logic [NUM_MASTERS-1:0] err_q, err_d;

    // to_cnt holds (grant cycle - 1), so it reads TIMEOUT_CYCLES-1 during the
    // last allowed cycle of the grant.
    assign timeout = (state_q == GRANT) && req[owner_q] &&
                     (to_cnt_q == TOW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        to_cnt_d = '0;
        if (state_q == GRANT)
            to_cnt_d = to_cnt_q + TOW'(1);
        // A timed-out master stays masked until an edge sees its req low.
        mask_d = (mask_q & req) | (timeout ? gnt_q : '0);
        err_d  = timeout ? gnt_q : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
            mask_q   <= '0;
            err_q    <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
            mask_q   <= mask_d;
            err_q    <= err_d;
        end
    end

    assign arb_req = req & ~mask_q;
    assign bus_err = err_q;
`else
    assign timeout = 1'b0;
    assign arb_req = req;
    assign bus_err = '0;
`endif

    // First eligible request searching upward from the pointer, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_MASTERS)
                idx = idx - NUM_MASTERS;
            if (!win_found && arb_req[idx]) begin
                win_found = 1'b1;
                win_idx   = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        turn_cnt_d = turn_cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d          = GRANT;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    owner_d          = win_idx;
                end
            end
            GRANT: begin
                // Release (or timeout) always passes through TURN, even when
                // other masters are already waiting.
                if (!req[owner_q] || timeout) begin
                    state_d    = TURN;
                    gnt_d      = '0;
                    ptr_d      = (owner_q == IDW'(NUM_MASTERS - 1)) ? '0 : owner_q + IDW'(1);
                    turn_cnt_d = '0;
                end
            end
            TURN: begin
                if (turn_cnt_q == TCW'(TURN_CYCLES - 1)) begin
                    if (win_found) begin
                        state_d        = GRANT;
                        gnt_d          = '0;
                        gnt_d[win_idx] = 1'b1;
                        owner_d        = win_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    turn_cnt_d = turn_cnt_q + TCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Reset wins over everything, including an active grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            turn_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            turn_cnt_q <= turn_cnt_d;
        end
    end

    // gnt_id is encoded from gnt itself so the two can never disagree.
    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (gnt_q[i])
                gnt_id = IDW'(i);
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign bus_park  = (state_q == IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//   Self-checking bench for bus_arbiter. DUT A (TURN_CYCLES=1, TIMEOUT_CYCLES=8)
//   runs a vector table plus hand sequences; DUT B (TURN_CYCLES=3) runs the
//   long-turnaround sequence. Expected outputs are queued when a vector is
//   driven and popped when the DUT output is sampled after the edge.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    logic       clk;
    logic       rst_a, rst_b;
    logic [3:0] req_a, req_b;
    logic [3:0] gnt_a, gnt_b, err_a, err_b;
    logic       val_a, val_b, park_a, park_b;
    logic [1:0] id_a, id_b;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic       park;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic       park;
        logic [3:0] err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_a[$];
    exp_t sb_b[$];

    bus_arbiter #(.NUM_MASTERS(4), .TURN_CYCLES(1), .TIMEOUT_CYCLES(8)) u_dut_a (
        .clk(clk), .rst(rst_a), .req(req_a), .gnt(gnt_a), .gnt_valid(val_a),
        .gnt_id(id_a), .bus_park(park_a), .bus_err(err_a)
    );

    bus_arbiter #(.NUM_MASTERS(4), .TURN_CYCLES(3), .TIMEOUT_CYCLES(8)) u_dut_b (
        .clk(clk), .rst(rst_b), .req(req_b), .gnt(gnt_b), .gnt_valid(val_b),
        .gnt_id(id_b), .bus_park(park_b), .bus_err(err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [1:0] id_of(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++)
            if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic check(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, step, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] q, input logic [3:0] g, input logic p);
        vec_t v;
        v.rst = r; v.req = q; v.gnt = g; v.park = p;
        vecs.push_back(v);
    endtask

    // Called #1 after a rising edge: drive, queue the expectation, clock, compare.
    task automatic step_a(input int n, input logic r, input logic [3:0] q,
                          input logic [3:0] g, input logic p, input logic [3:0] e);
        exp_t x, y;
        rst_a = r;
        req_a = q;
        x.gnt = g; x.park = p; x.err = e;
        sb_a.push_back(x);
        @(posedge clk);
        #1;
        y = sb_a.pop_front();
        check("a_gnt",       n, 32'(gnt_a),  32'(y.gnt));
        check("a_gnt_id",    n, 32'(id_a),   32'(id_of(y.gnt)));
        check("a_gnt_valid", n, 32'(val_a),  32'(|y.gnt));
        check("a_bus_park",  n, 32'(park_a), 32'(y.park));
        check("a_bus_err",   n, 32'(err_a),  32'(y.err));
        check("a_park_vs_valid", n, 32'(val_a & park_a), 32'd0);
    endtask

    task automatic step_b(input int n, input logic r, input logic [3:0] q,
                          input logic [3:0] g, input logic p);
        exp_t x, y;
        rst_b = r;
        req_b = q;
        x.gnt = g; x.park = p; x.err = 4'b0000;
        sb_b.push_back(x);
        @(posedge clk);
        #1;
        y = sb_b.pop_front();
        check("b_gnt",      n, 32'(gnt_b),  32'(y.gnt));
        check("b_gnt_id",   n, 32'(id_b),   32'(id_of(y.gnt)));
        check("b_bus_park", n, 32'(park_b), 32'(y.park));
        check("b_bus_err",  n, 32'(err_b),  32'(y.err));
    endtask

    initial begin
        // reset, single request, release, turn, park
        add(1, 4'b0000, 4'b0000, 1);
        add(1, 4'b0001, 4'b0000, 1);
        add(0, 4'b0000, 4'b0000, 1);
        add(0, 4'b0001, 4'b0001, 0);
        add(0, 4'b0001, 4'b0001, 0);
        add(0, 4'b0000, 4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 1);
        add(0, 4'b0000, 4'b0000, 1);
        // all request, each owner holds 3 cycles: order 0,1,2,3,0
        add(1, 4'b0000, 4'b0000, 1);
        add(0, 4'b1111, 4'b0001, 0);
        add(0, 4'b1111, 4'b0001, 0);
        add(0, 4'b1111, 4'b0001, 0);
        add(0, 4'b1110, 4'b0000, 0);
        add(0, 4'b1111, 4'b0010, 0);
        add(0, 4'b1111, 4'b0010, 0);
        add(0, 4'b1111, 4'b0010, 0);
        add(0, 4'b1101, 4'b0000, 0);
        add(0, 4'b1111, 4'b0100, 0);
        add(0, 4'b1111, 4'b0100, 0);
        add(0, 4'b1111, 4'b0100, 0);
        add(0, 4'b1011, 4'b0000, 0);
        add(0, 4'b1111, 4'b1000, 0);
        add(0, 4'b1111, 4'b1000, 0);
        add(0, 4'b1111, 4'b1000, 0);
        add(0, 4'b0111, 4'b0000, 0);
        add(0, 4'b1111, 4'b0001, 0);
        // owner 2 releases while 1011 pending, pointer at 3: then 3, 0, 1
        add(0, 4'b0100, 4'b0000, 0);
        add(0, 4'b0100, 4'b0100, 0);
        add(0, 4'b0100, 4'b0100, 0);
        add(0, 4'b1011, 4'b0000, 0);
        add(0, 4'b1011, 4'b1000, 0);
        add(0, 4'b0011, 4'b0000, 0);
        add(0, 4'b0011, 4'b0001, 0);
        add(0, 4'b0010, 4'b0000, 0);
        add(0, 4'b0010, 4'b0010, 0);
        add(0, 4'b0000, 4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 1);
        // reset during grant of master 3, then master 3 granted again
        add(0, 4'b1000, 4'b1000, 0);
        add(0, 4'b1000, 4'b1000, 0);
        add(1, 4'b1001, 4'b0000, 1);
        add(0, 4'b1000, 4'b1000, 0);
        add(0, 4'b1000, 4'b1000, 0);
        add(0, 4'b0000, 4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 1);

        rst_a = 1'b1; req_a = 4'b0000;
        rst_b = 1'b1; req_b = 4'b0000;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++)
            step_a(i, vecs[i].rst, vecs[i].req, vecs[i].gnt, vecs[i].park, 4'b0000);

        // a request pulse that starts and ends between edges is not seen
        req_a = 4'b0001;
        #3;
        req_a = 4'b0000;
        step_a(100, 0, 4'b0000, 4'b0000, 1, 4'b0000);

`ifdef BUS_ARBITER_TIMEOUT_EN
        // master 1 holds past TIMEOUT_CYCLES=8: error pulse, masked until req drops
        step_a(200, 1, 4'b0000, 4'b0000, 1, 4'b0000);
        for (int k = 0; k < 8; k++)
            step_a(201 + k, 0, 4'b0010, 4'b0010, 0, 4'b0000);
        step_a(209, 0, 4'b0010, 4'b0000, 0, 4'b0010);
        step_a(210, 0, 4'b0010, 4'b0000, 1, 4'b0000);
        step_a(211, 0, 4'b0010, 4'b0000, 1, 4'b0000);
        step_a(212, 0, 4'b0000, 4'b0000, 1, 4'b0000);
        step_a(213, 0, 4'b0010, 4'b0010, 0, 4'b0000);
`else
        // without the timeout a grant is held indefinitely
        step_a(200, 1, 4'b0000, 4'b0000, 1, 4'b0000);
        for (int k = 0; k < 12; k++)
            step_a(201 + k, 0, 4'b0010, 4'b0010, 0, 4'b0000);
`endif

        // TURN_CYCLES=3: master 1 releases while master 0 requests
        step_b(300, 1, 4'b0000, 4'b0000, 1);
        step_b(301, 0, 4'b0010, 4'b0010, 0);
        step_b(302, 0, 4'b0010, 4'b0010, 0);
        step_b(303, 0, 4'b0001, 4'b0000, 0);
        step_b(304, 0, 4'b0001, 4'b0000, 0);
        step_b(305, 0, 4'b0001, 4'b0000, 0);
        step_b(306, 0, 4'b0001, 4'b0001, 0);
        step_b(307, 0, 4'b0000, 4'b0000, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
